// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, quarter-wave sine ROM,
// square/saw/triangle synthesis, gain, offset and DAC strobes.
module dds_wave_gen #(
  parameter int PHASE_W  = 32,
  parameter int DAC_W    = 14,
  parameter int LUT_AW   = 10,
  parameter int AMP_W    = 10,
  parameter     SIN_FILE = "sin_q.hex"
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [1:0]         cfg_mode,
  input  logic [AMP_W:0]     cfg_amp,
  input  logic [DAC_W-1:0]   cfg_offset,
  output logic               da_clk,
  output logic               da_wrt,
  output logic [DAC_W-1:0]   da_data,
  output logic               data_valid,
  output logic               wrap
);

  localparam int N  = DAC_W;
  localparam int PW = N + AMP_W + 2;
  localparam unused_sin_file = SIN_FILE;

  localparam logic [AMP_W:0] UNITY = {1'b1, {AMP_W{1'b0}}};
  localparam logic [N-1:0] FS_N = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_FS_N = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N:0] FS_W = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] NEG_FS_W = -FS_W;

  typedef enum logic [1:0] {
    M_SINE   = 2'd0,
    M_SQUARE = 2'd1,
    M_SAW    = 2'd2,
    M_TRI    = 2'd3
  } mode_t;

  // ROM contents are evaluated at elaboration with a Taylor series.
  function automatic logic [N-2:0] sin_entry(input int i);
    real x;
    real term;
    real acc;
    x = 1.5707963267948966 * (real'(i) + 0.5) / real'(2 ** LUT_AW);
    term = x;
    acc = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc = acc + term;
    end
    return (N-1)'($rtoi(acc * real'(2 ** (N - 1) - 1) + 0.5));
  endfunction

  function automatic logic [N-1:0] clamp_min(input logic [N-1:0] v);
    return (v == MIN_N) ? NEG_FS_N : v;
  endfunction

  logic [N-2:0] rom [2**LUT_AW];

  for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
    localparam logic [N-2:0] ENTRY = sin_entry(gi);
    assign rom[gi] = ENTRY;
  end

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc_a;
  logic [PHASE_W-1:0] inc_s;
  mode_t              mode_a;
  mode_t              mode_s;
  logic [AMP_W:0]     amp_a;
  logic [AMP_W:0]     amp_s;
  logic [N-1:0]       off_a;
  logic [N-1:0]       off_s;
  logic               pending;

  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               accept;
  logic               apply;
  logic [AMP_W:0]     amp_in;

  assign cfg_ready = ~pending;
  assign accept = cfg_valid & ~pending;
  assign sum = {1'b0, phase} + {1'b0, inc_a};
  assign carry = en & sum[PHASE_W];
  assign apply = pending & (carry | ~en);
  assign amp_in = (cfg_amp > UNITY) ? UNITY : cfg_amp;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase   <= '0;
      pending <= 1'b0;
      inc_a   <= '0;
      mode_a  <= M_SINE;
      amp_a   <= UNITY;
      off_a   <= '0;
      inc_s   <= '0;
      mode_s  <= M_SINE;
      amp_s   <= UNITY;
      off_s   <= '0;
    end else begin
      if (en) phase <= sum[PHASE_W-1:0];
      if (accept) begin
        inc_s   <= cfg_phase_inc;
        mode_s  <= mode_t'(cfg_mode);
        amp_s   <= amp_in;
        off_s   <= cfg_offset;
        pending <= 1'b1;
      end else if (apply) begin
        inc_a   <= inc_s;
        mode_a  <= mode_s;
        amp_a   <= amp_s;
        off_a   <= off_s;
        pending <= 1'b0;
      end
    end
  end

  logic              neg;
  logic [LUT_AW-1:0] addr;
  logic [N-1:0]      saw_u;
  logic [N-1:0]      tri_t;
  logic [N-1:0]      wave;

  always_comb begin
    neg = phase[PHASE_W-1];
    addr = phase[PHASE_W-3 -: LUT_AW] ^ {LUT_AW{phase[PHASE_W-2]}};
    saw_u = phase[PHASE_W-1 -: N];
    tri_t = phase[PHASE_W-2 -: N] ^ {N{neg}};
    wave = '0;
    unique case (mode_a)
      M_SQUARE: wave = neg ? NEG_FS_N : FS_N;
      M_SAW:    wave = clamp_min({~saw_u[N-1], saw_u[N-2:0]});
      M_TRI:    wave = clamp_min({~tri_t[N-1], tri_t[N-2:0]});
      default:  wave = '0;
    endcase
  end

  mode_t          mode1;
  logic           neg1;
  logic [N-2:0]   rom_q;
  logic [N-1:0]   wave1;
  logic [AMP_W:0] amp1;
  logic [N-1:0]   off1;
  logic           v1;
  logic           wr0;
  logic           wr1;

  // Gain and offset travel with each sample so a config swap cannot
  // touch samples already in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode1 <= M_SINE;
      neg1  <= 1'b0;
      rom_q <= '0;
      wave1 <= '0;
      amp1  <= '0;
      off1  <= '0;
      v1    <= 1'b0;
      wr0   <= 1'b0;
      wr1   <= 1'b0;
    end else begin
      mode1 <= mode_a;
      neg1  <= neg;
      rom_q <= rom[addr];
      wave1 <= wave;
      amp1  <= amp_a;
      off1  <= off_a;
      v1    <= en;
      wr0   <= carry;
      wr1   <= wr0;
    end
  end

  logic signed [N-1:0]  mag;
  logic signed [N-1:0]  w_s;
  logic signed [PW-1:0] prod;

  always_comb begin
    mag = $signed({1'b0, rom_q});
    w_s = $signed(wave1);
    if (mode1 == M_SINE) w_s = neg1 ? -mag : mag;
    prod = PW'(w_s) * PW'($signed({1'b0, amp1}));
  end

  logic [N-1:0] g2;
  logic [N-1:0] off2;
  logic         v2;
  logic         wr2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      g2   <= '0;
      off2 <= '0;
      v2   <= 1'b0;
      wr2  <= 1'b0;
    end else begin
      g2   <= prod[AMP_W +: N];
      off2 <= off1;
      v2   <= v1;
      wr2  <= wr1;
    end
  end

  logic signed [N:0] s;
  logic signed [N:0] sat;

  always_comb begin
    s = $signed({g2[N-1], g2}) + $signed({off2[N-1], off2});
    sat = s;
    if (s > FS_W) sat = FS_W;
    else if (s < NEG_FS_W) sat = NEG_FS_W;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      da_data    <= MIN_N;
      data_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      da_data    <= {~sat[N-1], sat[N-2:0]};
      data_valid <= v2;
      wrap       <= wr2;
    end
  end

  assign da_clk = ~sys_clk;
  assign da_wrt = sys_clk;

  logic unused_bits;
  assign unused_bits = ^{phase[PHASE_W-N-2:0], prod[PW-1:AMP_W+N],
                         prod[AMP_W-1:0], sat[N]};

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: per-mode vector table plus
// config deferral and reset-with-pending sequences.
module tb_dds_wave_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_phase_inc;
  logic [1:0]  cfg_mode;
  logic [10:0] cfg_amp;
  logic [13:0] cfg_offset;
  logic        da_clk;
  logic        da_wrt;
  logic [13:0] da_data;
  logic        data_valid;
  logic        wrap;

  int n_pass = 0;
  int n_total = 0;

  always #5 sys_clk = ~sys_clk;

  dds_wave_gen dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .en            (en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_mode      (cfg_mode),
    .cfg_amp       (cfg_amp),
    .cfg_offset    (cfg_offset),
    .da_clk        (da_clk),
    .da_wrt        (da_wrt),
    .da_data       (da_data),
    .data_valid    (data_valid),
    .wrap          (wrap)
  );

  typedef struct {
    logic [1:0]        mode;
    logic [10:0]       amp;
    logic [13:0]       off;
    logic [0:3][13:0]  exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [31:0] inc,
                       input logic [10:0] amp, input logic [13:0] off);
    cfg_valid = 1'b1;
    cfg_mode = m;
    cfg_phase_inc = inc;
    cfg_amp = amp;
    cfg_offset = off;
  endtask

  task automatic setup_idle(input string nm, input logic [1:0] m,
                            input logic [31:0] inc, input logic [10:0] amp,
                            input logic [13:0] off);
    sys_rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    offer(m, inc, amp, off);
    tick();
    cfg_valid = 1'b0;
    @(negedge sys_clk);
    check({nm, "_rdy_pend"}, 32'(cfg_ready), 32'd0);
    tick();
    @(negedge sys_clk);
    check({nm, "_rdy_done"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic run_vec(input int vi);
    string nm;
    nm = $sformatf("vec%0d", vi);
    setup_idle(nm, vecs[vi].mode, 32'h4000_0000, vecs[vi].amp,
               vecs[vi].off);
    tick();
    en = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      check($sformatf("%s_s%0d_data", nm, k), 32'(da_data),
            32'(vecs[vi].exp[k % 4]));
      check($sformatf("%s_s%0d_wrap", nm, k), 32'(wrap),
            32'((k % 4 == 0) && (k > 0)));
      check($sformatf("%s_s%0d_valid", nm, k), 32'(data_valid), 32'd1);
      tick();
    end
    en = 1'b0;
  endtask

  function automatic logic [13:0] saw_exp(input int k);
    return (k == 0) ? 14'h0001 : 14'(k << 10);
  endfunction

  initial begin
    vecs[0] = '{mode: 2'd1, amp: 11'd1024, off: 14'h0000,
                exp: {14'h3FFF, 14'h3FFF, 14'h0001, 14'h0001}};
    vecs[1] = '{mode: 2'd0, amp: 11'd1024, off: 14'h0000,
                exp: {14'h2006, 14'h3FFF, 14'h1FFA, 14'h0001}};
    vecs[2] = '{mode: 2'd1, amp: 11'd512, off: 14'h0000,
                exp: {14'h2FFF, 14'h2FFF, 14'h1000, 14'h1000}};
    vecs[3] = '{mode: 2'd1, amp: 11'd1024, off: 14'h0FA0,
                exp: {14'h3FFF, 14'h3FFF, 14'h0FA1, 14'h0FA1}};
    vecs[4] = '{mode: 2'd1, amp: 11'd1024, off: 14'h3060,
                exp: {14'h305F, 14'h305F, 14'h0001, 14'h0001}};
    vecs[5] = '{mode: 2'd2, amp: 11'd2047, off: 14'h0000,
                exp: {14'h0001, 14'h1000, 14'h2000, 14'h3000}};
    vecs[6] = '{mode: 2'd3, amp: 11'd1024, off: 14'h0000,
                exp: {14'h0001, 14'h2000, 14'h3FFF, 14'h1FFF}};
    vecs[7] = '{mode: 2'd3, amp: 11'd512, off: 14'h0000,
                exp: {14'h1000, 14'h2000, 14'h2FFF, 14'h1FFF}};
    vecs[8] = '{mode: 2'd0, amp: 11'd512, off: 14'h0000,
                exp: {14'h2003, 14'h2FFF, 14'h1FFD, 14'h1000}};
    vecs[9] = '{mode: 2'd0, amp: 11'd0, off: 14'h0064,
                exp: {14'h2064, 14'h2064, 14'h2064, 14'h2064}};

    sys_rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    cfg_phase_inc = '0;
    cfg_mode = '0;
    cfg_amp = '0;
    cfg_offset = '0;

    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge sys_clk);
      check($sformatf("rst%0d_data", i), 32'(da_data), 32'h2000);
      check($sformatf("rst%0d_ready", i), 32'(cfg_ready), 32'd1);
      check($sformatf("rst%0d_valid", i), 32'(data_valid), 32'd0);
      check($sformatf("rst%0d_wrap", i), 32'(wrap), 32'd0);
    end

    for (int vi = 0; vi < 10; vi++) run_vec(vi);

    // Deferred application at the phase wrap.
    setup_idle("defer", 2'd2, 32'h1000_0000, 11'd1024, 14'h0000);
    tick();
    en = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cyc == 3)
        offer(2'd1, 32'h4000_0000, 11'd1024, 14'h0000);
      else if (cyc >= 4 && cyc <= 14)
        offer(2'd2, 32'h0800_0000, 11'd1024, 14'd1000);
      else
        cfg_valid = 1'b0;
      @(negedge sys_clk);
      check($sformatf("defer_c%0d_ready", cyc), 32'(cfg_ready),
            32'(!(cyc >= 4 && cyc <= 15)));
      if (cyc >= 3) begin
        int k;
        logic [13:0] e;
        k = cyc - 3;
        if (k < 16) e = saw_exp(k);
        else e = ((k - 16) % 4 < 2) ? 14'h3FFF : 14'h0001;
        check($sformatf("defer_k%0d_data", k), 32'(da_data), 32'(e));
        check($sformatf("defer_k%0d_wrap", k), 32'(wrap),
              32'((k >= 16) && ((k - 16) % 4 == 0)));
        check($sformatf("defer_k%0d_valid", k), 32'(data_valid), 32'd1);
      end
      tick();
    end
    en = 1'b0;

    // Reset while a config is pending.
    setup_idle("rstp", 2'd1, 32'h1000_0000, 11'd1024, 14'h0000);
    tick();
    en = 1'b1;
    tick();
    tick();
    offer(2'd2, 32'h0800_0000, 11'd1024, 14'd1000);
    tick();
    cfg_valid = 1'b0;
    @(negedge sys_clk);
    check("rstp_pending_ready", 32'(cfg_ready), 32'd0);
    tick();
    sys_rst = 1'b1;
    en = 1'b0;
    tick();
    @(negedge sys_clk);
    check("rstp_in_rst_ready", 32'(cfg_ready), 32'd1);
    check("rstp_in_rst_data", 32'(da_data), 32'h2000);
    check("rstp_in_rst_valid", 32'(data_valid), 32'd0);
    sys_rst = 1'b0;
    tick();
    @(negedge sys_clk);
    check("rstp_after_ready", 32'(cfg_ready), 32'd1);
    repeat (4) tick();
    @(negedge sys_clk);
    check("rstp_idle_data", 32'(da_data), 32'h2006);
    check("rstp_idle_ready", 32'(cfg_ready), 32'd1);
    check("rstp_idle_valid", 32'(data_valid), 32'd0);
    check("rstp_idle_wrap", 32'(wrap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
